ram_burst_ctrl: RTL and testbench
=================================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameters SHALL be: W, 32, data width; AW, 14, address width; D, 16384, RAM depth in words.
REQ-002 clk  in  1  single clock; all logic SHALL act on its rising edge.
REQ-003 reset  in  1  reset, synchronous and active-low: logic resets on a clk edge while reset=0.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  burst command handshake.
REQ-005 cmd_rw  in  1  burst direction: 1=write, 0=read.
REQ-006 cmd_addr  in  AW  first word address.
REQ-007 cmd_len  in  AW  burst length minus one, giving 1..16384 words.
REQ-008 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / W  write-data stream.
REQ-009 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / W  read-data stream.
REQ-010 busy  out  1  high whenever the block is not in IDLE.
REQ-011 done  out  1  one-cycle pulse at burst completion.
REQ-012 ram_we / ram_addr / ram_din  out / out / out  1 / AW / W  port to the 32x16384 RAM.
REQ-013 ram_dout  in  W  RAM read data, valid one clk after ram_addr is presented.

Function
REQ-014 FSM SHALL have states IDLE, WRITE, READ and DRAIN.
- IDLE -> WRITE or READ on cmd_valid&&cmd_ready, with direction from cmd_rw.
REQ-015 cmd_ready SHALL equal (state==IDLE); command fields SHALL be latched on acceptance.
REQ-016 WRITE state:
- wr_ready=1.
- ram_we = wr_valid, combinational.
- ram_addr = current address; ram_din = wr_data.
- Each accepted beat SHALL increment the address and decrement the remaining count.
REQ-017 Outside WRITE, ram_we SHALL be 0 and wr_ready SHALL be 0.
REQ-018 READ issue rule: an address is issued to the RAM only when (fifo_count + inflight) < 2.
- The read FIFO is 2 entries deep.
- inflight is 0 or 1.
REQ-019 A read issued in cycle c SHALL be pushed into the FIFO at the end of cycle c+1, making rd_valid visible in cycle c+2 at the earliest.
REQ-020 After the last read address is issued, the FSM SHALL go to DRAIN. DRAIN ends when inflight=0, the FIFO is empty, and the final pop occurs.
REQ-021 rd_valid SHALL equal "FIFO not empty"; rd_data SHALL be the FIFO head; a pop occurs on rd_valid&&rd_ready.
REQ-022 rd_ready low SHALL stall issue without any data loss or duplication; words SHALL come out in address order.
REQ-023 done timing:
- Write bursts: done pulses in the cycle after the last write beat is accepted.
- Read bursts: done pulses in the cycle after the last word is popped.
- The FSM then returns to IDLE.
REQ-024 Address arithmetic SHALL be modulo D, so 16383 + 1 = 0, unless REQ-029 applies.
REQ-025 The remaining count SHALL be AW+1 bits so that cmd_len=16383 yields exactly 16384 beats.

Reset
REQ-026 Reset SHALL be sampled only on a rising clk edge; there is no asynchronous path.
REQ-027 On reset:
- state=IDLE, the FIFO is flushed, inflight=0.
- done=0, busy=0, rd_valid=0, ram_we=0, ram_addr=0.
REQ-028 Reset mid-burst SHALL abort the burst: no done pulse, and no further ram_we is asserted.

Configuration
REQ-029 With macro RAM_BURST_CTRL_ERR_EN defined:
- Output err (1 bit) is added.
- A command with cmd_addr+cmd_len > D-1 SHALL be accepted, SHALL cause no RAM access, and SHALL pulse err and done together one cycle later.
- err resets to 0.
REQ-030 Without RAM_BURST_CTRL_ERR_EN, there is no err port and bursts wrap modulo D.

Structure
REQ-031 A shared package SHALL hold W, AW, D and the FSM state encoding (2 bits).
REQ-032 The 2-entry read FIFO SHALL be a sub-module named ram_burst_fifo2, with push, pop, count, full and empty.

Verification
REQ-033 Write burst:
- Stimulus: cmd_rw=1, addr=0x0010, len=3; wr_data 0xA0..0xA3 with wr_valid held high.
- Required: ram_we high for 4 cycles at addresses 0x10..0x13; done pulses one cycle after the last beat.
REQ-034 Read burst without backpressure:
- Stimulus: read addr=0x0010, len=3 with rd_ready=1.
- Required: rd_data 0xA0..0xA3 in order, first rd_valid 2 cycles after the first issue.
REQ-035 Read with backpressure:
- Stimulus: rd_ready toggling 1,0,0,1 during the REQ-034 read.
- Required: no word lost or duplicated; the FIFO never exceeds 2 entries.
REQ-036 Wrap boundary:
- Stimulus: write addr=0x3FFE, len=2.
- Required without macro: addresses 0x3FFE, 0x3FFF, 0x0000.
- Required with macro: err=1, done=1, ram_we never asserted.
REQ-037 Reset mid-burst:
- Stimulus: reset=0 for 1 cycle after the 2nd beat of a len=7 write.
- Required: ram_we=0 from the next cycle, state IDLE, no done pulse, and cmd_ready=1 after reset is released.

Source files
------------

// File: rtl/ram_burst_ctrl_pkg.sv
// ram_burst_ctrl_pkg: shared sizes and FSM encoding for the RAM burst controller.
`default_nettype none

package ram_burst_ctrl_pkg;
  localparam int W  = 32;
  localparam int AW = 14;
  localparam int D  = 16384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/ram_burst_fifo2.sv
// ram_burst_fifo2: two-entry read-data FIFO with synchronous active-low reset.
`default_nettype none

module ram_burst_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wp <= ~wp;
      if (do_pop)  rp <= ~rp;
      if (do_push && !do_pop)      count <= count + 2'd1;
      else if (do_pop && !do_push) count <= count - 2'd1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write controller for a single-port synchronous RAM.
// Optional RAM_BURST_CTRL_ERR_EN rejects bursts that would run past the last word.
`default_nettype none

module ram_burst_ctrl #(
  parameter int W  = ram_burst_ctrl_pkg::W,
  parameter int AW = ram_burst_ctrl_pkg::AW,
  parameter int D  = ram_burst_ctrl_pkg::D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [W-1:0]  wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [W-1:0]  ram_din,
  input  logic [W-1:0]  ram_dout
`ifdef RAM_BURST_CTRL_ERR_EN
  ,
  output logic          err
`endif
);
  import ram_burst_ctrl_pkg::*;

  state_t        state, next_state;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;
  logic          inflight;
  logic          accept, beat, issue, finish, bad_cmd;
  logic          pop, fifo_full, fifo_empty;
  logic [1:0]    fifo_count;
  logic [AW:0]   addr_inc;
  logic [AW-1:0] addr_next;
  logic          last;

  assign addr_inc  = {1'b0, addr} + (AW+1)'(1);
  assign addr_next = (addr_inc == (AW+1)'(D)) ? '0 : addr_inc[AW-1:0];
  assign last      = (remaining == (AW+1)'(1));

`ifdef RAM_BURST_CTRL_ERR_EN
  assign bad_cmd = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > (AW+1)'(D - 1);
`else
  assign bad_cmd = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Gated by reset so an aborted burst never writes during the reset cycle.
  assign wr_ready  = (state == WRITE) && reset;
  assign ram_we    = wr_ready && wr_valid;
  assign ram_addr  = addr;
  assign ram_din   = wr_data;
  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    beat       = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (!bad_cmd) next_state = cmd_rw ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          beat = 1'b1;
          if (last) begin
            next_state = IDLE;
            finish     = 1'b1;
          end
        end
      end
      READ: begin
        // Equivalent to fifo_count + inflight < 2.
        if (!fifo_full && !(fifo_count == 2'd1 && inflight)) begin
          issue = 1'b1;
          if (last) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && fifo_count == 2'd1 && pop) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= finish || (accept && bad_cmd);
      inflight <= issue;
      if (accept) begin
        addr      <= cmd_addr;
        remaining <= {1'b0, cmd_len} + (AW+1)'(1);
      end else if (beat || issue) begin
        addr      <= addr_next;
        remaining <= remaining - (AW+1)'(1);
      end
    end
  end

`ifdef RAM_BURST_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) err <= 1'b0;
    else        err <= accept && bad_cmd;
  end
`endif

  ram_burst_fifo2 #(.W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (ram_dout),
    .pop   (pop),
    .dout  (rd_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed self-checking bench for ram_burst_ctrl with a behavioural RAM.
`default_nettype none

module tb_ram_burst_ctrl;
  localparam int W  = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_rw;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid, rd_ready;
  logic [W-1:0]  rd_data;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din, ram_dout;
`ifdef RAM_BURST_CTRL_ERR_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [16384];
  logic [W-1:0] rdq [$];
  int           done_cnt = 0;
  int           we_cnt   = 0;
  int           fifo_max = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_BURST_CTRL_ERR_EN
    , .err(err)
`endif
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (rd_valid && rd_ready) rdq.push_back(rd_data);
    if (done) done_cnt++;
    if (ram_we) we_cnt++;
    if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int cyc;
  int base_done;
  int base_we;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;

    // Reset state
    repeat (2) next_cycle();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    reset = 1'b1;
    next_cycle();
    check("idle_cmd_ready", cmd_ready, 1);

    // Write burst 0x10, len 3
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 14'h0010; cmd_len = 14'd3;
    next_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'hA0 + i;
      #1;
      check("wr_ram_we", ram_we, 1);
      check("wr_ready", wr_ready, 1);
      check("wr_ram_addr", ram_addr, 32'h10 + i);
      check("wr_ram_din", ram_din, 32'hA0 + i);
      check("wr_busy", busy, 1);
      next_cycle();
    end
    wr_valid = 1'b0;
    #1;
    check("wr_done", done, 1);
    check("wr_idle", busy, 0);
    check("wr_we_off", ram_we, 0);
    next_cycle();
    check("wr_done_pulse", done, 0);

    // Read burst, no backpressure
    rdq.delete();
    rd_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 14'h0010; cmd_len = 14'd3;
    next_cycle();
    cmd_valid = 1'b0;
    check("rd_first_addr", ram_addr, 32'h10);
    check("rd_valid_c0", rd_valid, 0);
    next_cycle();
    check("rd_valid_c1", rd_valid, 0);
    next_cycle();
    check("rd_valid_c2", rd_valid, 1);
    check("rd_first_data", rd_data, 32'hA0);
    cyc = 0;
    while (!done && cyc < 50) begin
      next_cycle();
      cyc++;
    end
    check("rd_done", done, 1);
    check("rd_count", rdq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("rd_data", (i < rdq.size()) ? rdq[i] : 32'hDEAD_BEEF, 32'hA0 + i);
    next_cycle();

    // Read burst with rd_ready toggling 1,0,0,1
    rdq.delete();
    fifo_max = 0;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 14'h0010; cmd_len = 14'd3;
    next_cycle();
    cmd_valid = 1'b0;
    cyc = 0;
    rd_ready = pat[0];
    #1;
    while (!done && cyc < 80) begin
      next_cycle();
      cyc++;
      rd_ready = pat[cyc % 4];
      #1;
    end
    check("bp_done", done, 1);
    check("bp_count", rdq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp_data", (i < rdq.size()) ? rdq[i] : 32'hDEAD_BEEF, 32'hA0 + i);
    check("bp_fifo_max", (fifo_max <= 2) ? 1 : 0, 1);
    rd_ready = 1'b1;
    next_cycle();

    // Wrap boundary write 0x3FFE, len 2
    base_we = we_cnt;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 14'h3FFE; cmd_len = 14'd2;
    next_cycle();
    cmd_valid = 1'b0;
`ifdef RAM_BURST_CTRL_ERR_EN
    wr_valid = 1'b1; wr_data = 32'hB0;
    #1;
    check("err_flag", err, 1);
    check("err_done", done, 1);
    check("err_no_we", ram_we, 0);
    next_cycle();
    check("err_pulse", err, 0);
    wr_valid = 1'b0;
    next_cycle();
    check("err_we_cnt", we_cnt - base_we, 0);
`else
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 32'hB0 + i;
      #1;
      check("wrap_we", ram_we, 1);
      check("wrap_addr", ram_addr, (i == 2) ? 32'h0000 : (32'h3FFE + i));
      next_cycle();
    end
    wr_valid = 1'b0;
    #1;
    check("wrap_done", done, 1);
    next_cycle();
`endif

    // Reset in the middle of a len=7 write burst
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 14'h0100; cmd_len = 14'd7;
    next_cycle();
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hC0;
    next_cycle();
    wr_data = 32'hC1;
    next_cycle();
    base_done = done_cnt;
    reset = 1'b0; wr_data = 32'hC2;
    #1;
    check("mid_rst_we", ram_we, 0);
    next_cycle();
    reset = 1'b1; wr_data = 32'hC3;
    #1;
    check("mid_rst_we_after", ram_we, 0);
    check("mid_rst_idle", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    wr_valid = 1'b0;
    repeat (4) next_cycle();
    check("mid_rst_no_done", done_cnt - base_done, 0);
    check("mid_rst_written", mem[14'h0101], 32'hC1);
    check("mid_rst_not_written", mem[14'h0102], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
